// File: rtl/apb_slave_mem.sv
// APB slave with a small register-file memory, programmable wait states,
// out-of-range error response, sticky protocol checking and a transfer counter.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  proto_err,
  output logic [15:0]           xfer_count
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    range_err_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_q;
  logic                    mismatch;
  logic                    complete;
  logic                    mem_we;

  assign in_range = (32'(PADDR) < DEPTH_U);
  assign idx      = PADDR[IDX_W-1:0];
  assign idx_q    = addr_q[IDX_W-1:0];
  assign mismatch = (PADDR != addr_q) || (PWRITE != write_q) || (PWDATA != wdata_q);
  assign complete = (state == ACCESS) && PREADY && PSEL && PENABLE;
  assign mem_we   = complete && write_q && !range_err_q;

  // Response outputs depend on registers only, never on the bus inputs.
  assign PREADY  = (state == ACCESS) && (wait_cnt == 4'd0);
  assign PSLVERR = PREADY && range_err_q;
  assign PRDATA  = (PREADY && !write_q) ? rdata_q : '0;

  // Transfer FSM: latch the setup phase, count wait states, complete or abort.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      range_err_q <= 1'b0;
      proto_err   <= 1'b0;
      xfer_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q      <= PADDR;
            write_q     <= PWRITE;
            wdata_q     <= PWDATA;
            wait_cnt    <= 4'(WAIT_CYCLES);
            // Read data is captured at setup; a write completing one edge
            // earlier has already landed in mem, so no bypass is needed.
            rdata_q     <= in_range ? mem[idx] : '0;
            range_err_q <= !in_range;
            state       <= ACCESS;
          end else if (PSEL && PENABLE) begin
            // Access phase without a preceding setup phase.
            proto_err <= 1'b1;
          end
        end
        ACCESS: begin
          // Bus qualifiers must hold steady; the latched copy is used regardless.
          if (PSEL && mismatch) begin
            proto_err <= 1'b1;
          end
          if (!PSEL || !PENABLE) begin
            proto_err <= 1'b1;
            wait_cnt  <= 4'd0;
            state     <= IDLE;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            xfer_count <= xfer_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: cleared on reset, written only by a completed in-range write.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
